// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, WB write port, hazard output and ID/EX outputs.
interface decode_cycle_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   // IF/ID register contents
   logic [XLEN-1:0]       InstrD;
   logic [XLEN-1:0]       PCD;
   logic [XLEN-1:0]       PCPlus4D;
   // control from EX and write-back port
   logic                  FlushE;
   logic                  RegWriteW;
   logic [REG_ADDR_W-1:0] RdW;
   logic [XLEN-1:0]       ResultW;
   // hazard request
   logic                  StallD;
   // ID/EX register contents
   logic                  RegWriteE;
   logic                  MemWriteE;
   logic                  JumpE;
   logic                  BranchE;
   logic                  ALUSrcE;
   logic                  ALUSrcAE;
   logic                  IllegalE;
   logic [1:0]            ResultSrcE;
   logic [3:0]            ALUControlE;
   logic [2:0]            Funct3E;
   logic [XLEN-1:0]       RD1E;
   logic [XLEN-1:0]       RD2E;
   logic [XLEN-1:0]       ImmExtE;
   logic [XLEN-1:0]       PCE;
   logic [XLEN-1:0]       PCPlus4E;
   logic [REG_ADDR_W-1:0] Rs1E;
   logic [REG_ADDR_W-1:0] Rs2E;
   logic [REG_ADDR_W-1:0] RdE;

   modport master (
      output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
      input  StallD,
      input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, IllegalE,
      input  ResultSrcE, ALUControlE, Funct3E,
      input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
      output StallD,
      output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, IllegalE,
      output ResultSrcE, ALUControlE, Funct3E,
      output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
   );
endinterface

// File: rtl/decode_cycle.sv
// Instruction-decode stage: register file, control decoder, immediate
// generator, load-use hazard detection and the ID/EX pipeline register.
// Optional feature macro: REGFILE_BYPASS_EN (write-through regfile reads;
// when undefined, a WB-to-D register match stalls instead).
module decode_cycle #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic          clk,
   input  logic          reset,
   decode_cycle_if.slave dif
);

   localparam int unsigned NREGS = 1 << REG_ADDR_W;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_PASS = 4'b1010;

   logic [XLEN-1:0]       rf [NREGS];

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  alt;
   logic [REG_ADDR_W-1:0] rs1d;
   logic [REG_ADDR_W-1:0] rs2d;
   logic [REG_ADDR_W-1:0] rdd;

   logic [XLEN-1:0]       rd1;
   logic [XLEN-1:0]       rd2;
   logic [XLEN-1:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]            alu_f3;

   logic                  c_regwrite, c_memwrite, c_jump, c_branch;
   logic                  c_alusrc, c_alusrca, c_illegal;
   logic [1:0]            c_resultsrc;
   logic [3:0]            c_alu;
   logic [XLEN-1:0]       c_imm;

   logic                  use_rs2;
   logic                  load_hit;
   logic                  stall;

   assign opcode = dif.InstrD[6:0];
   assign funct3 = dif.InstrD[14:12];
   assign alt    = dif.InstrD[30];
   assign rs1d   = dif.InstrD[19:15];
   assign rs2d   = dif.InstrD[24:20];
   assign rdd    = dif.InstrD[11:7];

   // Immediate formats, all sign-extended from bit 31.
   assign imm_i = {{20{dif.InstrD[31]}}, dif.InstrD[31:20]};
   assign imm_s = {{20{dif.InstrD[31]}}, dif.InstrD[31:25], dif.InstrD[11:7]};
   assign imm_b = {{19{dif.InstrD[31]}}, dif.InstrD[31], dif.InstrD[7],
                   dif.InstrD[30:25], dif.InstrD[11:8], 1'b0};
   assign imm_u = {dif.InstrD[31:12], 12'b0};
   assign imm_j = {{11{dif.InstrD[31]}}, dif.InstrD[31], dif.InstrD[19:12],
                   dif.InstrD[20], dif.InstrD[30:21], 1'b0};

   // Register file read ports; x0 is hard-wired to zero.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
`ifdef REGFILE_BYPASS_EN
      if (rs1d != '0)
         rd1 = (dif.RegWriteW && dif.RdW == rs1d) ? dif.ResultW : rf[rs1d];
      if (rs2d != '0)
         rd2 = (dif.RegWriteW && dif.RdW == rs2d) ? dif.ResultW : rf[rs2d];
`else
      if (rs1d != '0)
         rd1 = rf[rs1d];
      if (rs2d != '0)
         rd2 = rf[rs2d];
`endif
   end

   // Register-register / register-immediate ALU operation from funct3.
   always_comb begin
      alu_f3 = ALU_ADD;
      case (funct3)
         3'b000:  alu_f3 = ALU_ADD;
         3'b001:  alu_f3 = ALU_SLL;
         3'b010:  alu_f3 = ALU_SLT;
         3'b011:  alu_f3 = ALU_SLTU;
         3'b100:  alu_f3 = ALU_XOR;
         3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   end

   // Main control decoder; unknown opcodes decode to all-zero controls plus illegal.
   always_comb begin
      c_regwrite  = 1'b0;
      c_memwrite  = 1'b0;
      c_jump      = 1'b0;
      c_branch    = 1'b0;
      c_alusrc    = 1'b0;
      c_alusrca   = 1'b0;
      c_illegal   = 1'b0;
      c_resultsrc = 2'b00;
      c_alu       = ALU_ADD;
      c_imm       = '0;
      case (opcode)
         OP_R: begin
            c_regwrite = 1'b1;
            c_alu      = (funct3 == 3'b000 && alt) ? ALU_SUB : alu_f3;
         end
         OP_IALU: begin
            c_regwrite = 1'b1;
            c_alusrc   = 1'b1;
            c_alu      = alu_f3;
            c_imm      = imm_i;
         end
         OP_LOAD: begin
            c_regwrite  = 1'b1;
            c_alusrc    = 1'b1;
            c_resultsrc = 2'b01;
            c_imm       = imm_i;
         end
         OP_STORE: begin
            c_memwrite = 1'b1;
            c_alusrc   = 1'b1;
            c_imm      = imm_s;
         end
         OP_BRANCH: begin
            c_branch = 1'b1;
            c_alu    = ALU_SUB;
            c_imm    = imm_b;
         end
         OP_JAL: begin
            c_regwrite  = 1'b1;
            c_jump      = 1'b1;
            c_resultsrc = 2'b10;
            c_imm       = imm_j;
         end
         OP_JALR: begin
            c_regwrite  = 1'b1;
            c_jump      = 1'b1;
            c_alusrc    = 1'b1;
            c_resultsrc = 2'b10;
            c_imm       = imm_i;
         end
         OP_LUI: begin
            c_regwrite = 1'b1;
            c_alusrc   = 1'b1;
            c_alu      = ALU_PASS;
            c_imm      = imm_u;
         end
         OP_AUIPC: begin
            c_regwrite = 1'b1;
            c_alusrc   = 1'b1;
            c_alusrca  = 1'b1;
            c_imm      = imm_u;
         end
         default: c_illegal = 1'b1;
      endcase
   end

   // Hazard detection: load in EX (and, without write-through, WB) feeding rs1/rs2.
   always_comb begin
      use_rs2  = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
      load_hit = (dif.ResultSrcE == 2'b01) && dif.RegWriteE && (dif.RdE != '0) &&
                 ((dif.RdE == rs1d) || (use_rs2 && dif.RdE == rs2d));
`ifdef REGFILE_BYPASS_EN
      stall    = !reset && !dif.FlushE && load_hit;
`else
      stall    = !reset && !dif.FlushE &&
                 (load_hit ||
                  (dif.RegWriteW && (dif.RdW != '0) &&
                   ((dif.RdW == rs1d) || (use_rs2 && dif.RdW == rs2d))));
`endif
   end

   assign dif.StallD = stall;

   // Register file write port from WB; x0 never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++)
            rf[REG_ADDR_W'(i)] <= '0;
      end else if (dif.RegWriteW && dif.RdW != '0) begin
         rf[dif.RdW] <= dif.ResultW;
      end
   end

   // ID/EX register: reset or flush/stall inserts an all-zero bubble.
   always_ff @(posedge clk) begin
      if (reset || dif.FlushE || stall) begin
         dif.RegWriteE   <= 1'b0;
         dif.MemWriteE   <= 1'b0;
         dif.JumpE       <= 1'b0;
         dif.BranchE     <= 1'b0;
         dif.ALUSrcE     <= 1'b0;
         dif.ALUSrcAE    <= 1'b0;
         dif.IllegalE    <= 1'b0;
         dif.ResultSrcE  <= 2'b00;
         dif.ALUControlE <= 4'b0000;
         dif.Funct3E     <= 3'b000;
         dif.RD1E        <= '0;
         dif.RD2E        <= '0;
         dif.ImmExtE     <= '0;
         dif.PCE         <= '0;
         dif.PCPlus4E    <= '0;
         dif.Rs1E        <= '0;
         dif.Rs2E        <= '0;
         dif.RdE         <= '0;
      end else begin
         dif.RegWriteE   <= c_regwrite;
         dif.MemWriteE   <= c_memwrite;
         dif.JumpE       <= c_jump;
         dif.BranchE     <= c_branch;
         dif.ALUSrcE     <= c_alusrc;
         dif.ALUSrcAE    <= c_alusrca;
         dif.IllegalE    <= c_illegal;
         dif.ResultSrcE  <= c_resultsrc;
         dif.ALUControlE <= c_alu;
         dif.Funct3E     <= funct3;
         dif.RD1E        <= rd1;
         dif.RD2E        <= rd2;
         dif.ImmExtE     <= c_imm;
         dif.PCE         <= dif.PCD;
         dif.PCPlus4E    <= dif.PCPlus4D;
         dif.Rs1E        <= rs1d;
         dif.Rs2E        <= rs2d;
         dif.RdE         <= rdd;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized
// instruction streams against a behavioural model of the decode stage.
module tb_decode_cycle;

   typedef struct packed {
      logic        rw, mw, j, b, asrc, asrca, ill;
      logic [1:0]  rsrc;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } ide_t;

   logic clk = 1'b0;
   logic reset;
   decode_cycle_if dif ();

   decode_cycle dut (.clk(clk), .reset(reset), .dif(dif));

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] mregs [32];
   ide_t        exp_e;
   logic        exp_stall;
   logic [3:0]  f3alu [8];
   logic [6:0]  ops [10];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] mread(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (dif.RegWriteW && dif.RdW == idx) return dif.ResultW;
`endif
      return mregs[idx];
   endfunction

   function automatic logic reads_rs2(input logic [6:0] op);
      return op == 7'h33 || op == 7'h23 || op == 7'h63;
   endfunction

   function automatic logic model_stall();
      logic [4:0] r1, r2;
      logic u2, hit;
      r1 = dif.InstrD[19:15];
      r2 = dif.InstrD[24:20];
      u2 = reads_rs2(dif.InstrD[6:0]);
      hit = exp_e.rsrc == 2'b01 && exp_e.rw && exp_e.rd != 0 &&
            (exp_e.rd == r1 || (u2 && exp_e.rd == r2));
`ifndef REGFILE_BYPASS_EN
      hit = hit || (dif.RegWriteW && dif.RdW != 0 &&
                    (dif.RdW == r1 || (u2 && dif.RdW == r2)));
`endif
      return !reset && !dif.FlushE && hit;
   endfunction

   // What an instruction means, independent of pipeline state.
   function automatic ide_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] pc4);
      ide_t e;
      logic [2:0] f3;
      logic signed [12:0] bimm;
      logic signed [20:0] jimm;
      logic [31:0] immi, imms, immb, immu, immj;
      e = '0;
      f3 = ins[14:12];
      immi = 32'($signed(ins) >>> 20);
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      immb = 32'(bimm);
      immj = 32'(jimm);
      immu = ins & 32'hFFFF_F000;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.f3 = f3; e.pc = pc; e.pc4 = pc4;
      e.rd1 = mread(ins[19:15]);
      e.rd2 = mread(ins[24:20]);
      case (ins[6:0])
         7'h33: begin
            e.rw = 1; e.alu = f3alu[f3];
            if (ins[30] && f3 == 3'd0) e.alu = 4'd1;
            if (ins[30] && f3 == 3'd5) e.alu = 4'd9;
         end
         7'h13: begin
            e.rw = 1; e.asrc = 1; e.imm = immi; e.alu = f3alu[f3];
            if (ins[30] && f3 == 3'd5) e.alu = 4'd9;
         end
         7'h03: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01; e.imm = immi; end
         7'h23: begin e.mw = 1; e.asrc = 1; e.imm = imms; end
         7'h63: begin e.b = 1; e.alu = 4'd1; e.imm = immb; end
         7'h6F: begin e.rw = 1; e.j = 1; e.rsrc = 2'b10; e.imm = immj; end
         7'h67: begin e.rw = 1; e.j = 1; e.asrc = 1; e.rsrc = 2'b10; e.imm = immi; end
         7'h37: begin e.rw = 1; e.asrc = 1; e.alu = 4'd10; e.imm = immu; end
         7'h17: begin e.rw = 1; e.asrc = 1; e.asrca = 1; e.imm = immu; end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   task automatic check_e();
      chk("RegWriteE", 32'(dif.RegWriteE), 32'(exp_e.rw));
      chk("MemWriteE", 32'(dif.MemWriteE), 32'(exp_e.mw));
      chk("JumpE", 32'(dif.JumpE), 32'(exp_e.j));
      chk("BranchE", 32'(dif.BranchE), 32'(exp_e.b));
      chk("ALUSrcE", 32'(dif.ALUSrcE), 32'(exp_e.asrc));
      chk("ALUSrcAE", 32'(dif.ALUSrcAE), 32'(exp_e.asrca));
      chk("IllegalE", 32'(dif.IllegalE), 32'(exp_e.ill));
      chk("ResultSrcE", 32'(dif.ResultSrcE), 32'(exp_e.rsrc));
      chk("ALUControlE", 32'(dif.ALUControlE), 32'(exp_e.alu));
      chk("Funct3E", 32'(dif.Funct3E), 32'(exp_e.f3));
      chk("RD1E", dif.RD1E, exp_e.rd1);
      chk("RD2E", dif.RD2E, exp_e.rd2);
      chk("ImmExtE", dif.ImmExtE, exp_e.imm);
      chk("PCE", dif.PCE, exp_e.pc);
      chk("PCPlus4E", dif.PCPlus4E, exp_e.pc4);
      chk("Rs1E", 32'(dif.Rs1E), 32'(exp_e.rs1));
      chk("Rs2E", 32'(dif.Rs2E), 32'(exp_e.rs2));
      chk("RdE", 32'(dif.RdE), 32'(exp_e.rd));
   endtask

   // One clock: check stall before the edge, advance the model, check ID/EX after.
   task automatic step();
      ide_t nxt;
      #1;
      exp_stall = model_stall();
      chk("StallD", 32'(dif.StallD), 32'(exp_stall));
      if (reset || dif.FlushE || exp_stall) nxt = '0;
      else nxt = ref_decode(dif.InstrD, dif.PCD, dif.PCPlus4D);
      @(posedge clk);
      exp_e = nxt;
      if (reset) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else if (dif.RegWriteW && dif.RdW != 5'd0) begin
         mregs[dif.RdW] = dif.ResultW;
      end
      @(negedge clk);
      check_e();
   endtask

   task automatic drive(input logic rst, input logic [31:0] ins, input logic fl,
                        input logic rw, input logic [4:0] rdw, input logic [31:0] res);
      reset = rst;
      dif.InstrD = ins;
      dif.PCD = 32'h0000_1000 + 32'(n_cmp[7:0]) * 4;
      dif.PCPlus4D = dif.PCD + 32'd4;
      dif.FlushE = fl;
      dif.RegWriteW = rw;
      dif.RdW = rdw;
      dif.ResultW = res;
   endtask

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] ADD_4_3  = {7'h00, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33};
   localparam logic [31:0] ADD_1_5  = {7'h00, 5'd0, 5'd5, 3'b000, 5'd1, 7'h33};
   localparam logic [31:0] ADD_1_0  = {7'h00, 5'd0, 5'd0, 3'b000, 5'd1, 7'h33};
   localparam logic [31:0] ADD_1_9  = {7'h00, 5'd0, 5'd9, 3'b000, 5'd1, 7'h33};
   localparam logic [31:0] LW_6     = {12'd8, 5'd2, 3'b010, 5'd6, 7'h03};
   localparam logic [31:0] ADD_7_61 = {7'h00, 5'd1, 5'd6, 3'b000, 5'd7, 7'h33};
   localparam logic [31:0] BEQ_M4   = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000,
                                       4'b1110, 1'b1, 7'h63};

   initial begin
      logic [31:0] ins;
      f3alu = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      ops   = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      exp_e = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

      // reset for two cycles, then read x5
      drive(1'b1, NOP, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      step();
      chk("rst_regwrite", 32'(dif.RegWriteE), 32'd0);
      chk("rst_pce", dif.PCE, 32'd0);
      drive(1'b0, ADD_1_5, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      chk("read_x5", dif.RD1E, 32'd0);

      // WB write then read back
      drive(1'b0, NOP, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      step();
      drive(1'b0, ADD_4_3, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      chk("wb_rd1", dif.RD1E, 32'hDEAD_BEEF);
      chk("wb_alu", 32'(dif.ALUControlE), 32'd0);
      chk("wb_regwrite", 32'(dif.RegWriteE), 32'd1);

      // load-use: one stall cycle, bubble, then dependent add
      drive(1'b0, LW_6, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b0, ADD_7_61, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("lu_stall", 32'(dif.StallD), 32'd1);
      step();
      chk("lu_bubble", 32'(dif.RegWriteE), 32'd0);
      #1 chk("lu_stall_done", 32'(dif.StallD), 32'd0);
      step();
      chk("lu_rs1e", 32'(dif.Rs1E), 32'd6);

      // load-use while flushing: flush wins
      drive(1'b0, LW_6, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b0, ADD_7_61, 1'b1, 1'b0, 5'd0, 32'd0);
      #1 chk("flush_stall", 32'(dif.StallD), 32'd0);
      step();

      // branch flushed, then captured
      drive(1'b0, BEQ_M4, 1'b1, 1'b0, 5'd0, 32'd0);
      step();
      chk("flush_branch", 32'(dif.BranchE), 32'd0);
      drive(1'b0, BEQ_M4, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      chk("beq_imm", dif.ImmExtE, 32'hFFFF_FFFC);
      chk("beq_branch", 32'(dif.BranchE), 32'd1);
      chk("beq_alu", 32'(dif.ALUControlE), 32'd1);

      // reset during a stall
      drive(1'b0, LW_6, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b1, ADD_7_61, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("rst_mid_stall", 32'(dif.StallD), 32'd0);
      step();
      drive(1'b0, NOP, 1'b0, 1'b0, 5'd0, 32'd0);
      step();

      // x0 stays zero; illegal opcode
      drive(1'b0, NOP, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
      step();
      drive(1'b0, ADD_1_0, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      chk("x0_zero", dif.RD1E, 32'd0);
      drive(1'b0, 32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      chk("ill_flag", 32'(dif.IllegalE), 32'd1);
      chk("ill_regwrite", 32'(dif.RegWriteE), 32'd0);

      // same-cycle WB write and D read of x9
      drive(1'b0, ADD_1_9, 1'b0, 1'b1, 5'd9, 32'h0000_0055);
`ifdef REGFILE_BYPASS_EN
      step();
      chk("bypass_rd1", dif.RD1E, 32'h0000_0055);
`else
      #1 chk("wb_stall", 32'(dif.StallD), 32'd1);
      step();
      drive(1'b0, ADD_1_9, 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      chk("after_wb_rd1", dif.RD1E, 32'h0000_0055);
`endif

      // randomized instruction stream; a stalled instruction is held in D
      ins = NOP;
      for (int c = 0; c < 1500; c++) begin
         if (!exp_stall) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
         end
         drive($urandom_range(0, 99) == 0, ins, $urandom_range(0, 9) == 0,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
